// File: rtl/multdiv_seq_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package multdiv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // X-stage decode values that the pipeline compares against to form is_mult/is_div
    localparam logic [4:0] OPCODE_RTYPE = 5'b00000;
    localparam logic [4:0] ALUOP_MUL    = 5'b00110;
    localparam logic [4:0] ALUOP_DIV    = 5'b00111;

    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/multdiv_watchdog.sv
// Saturating busy-cycle counter with clear, enable and terminal-count compare.
// Latency: expired is combinational from the count; count updates on the next edge.
// Backpressure: none; clr has priority over en.
module multdiv_watchdog #(
    parameter int CNT_W   = 7,
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    // Fires during the TIMEOUT-th enabled cycle so DONE follows exactly TIMEOUT busy cycles
    assign expired = en && (count == TERM_CNT);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences the iterative mul/div unit for X: latch operands, one start pulse, stall, one-cycle result strobe.
// Latency: stall for L+2 cycles (L = unit latency), result_valid in cycle L+2 after detect.
// Backpressure: stall freezes the pipeline; flush cancels. Watchdog built only with MULTDIV_TIMEOUT_EN.
module multdiv_sequencer
    import multdiv_seq_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        is_mult,
    input  logic        is_div,
    input  logic        flush,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [31:0] unit_result,
    input  logic        unit_exception,
    input  logic        unit_rdy,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] unit_operand_a,
    output logic [31:0] unit_operand_b,
    output logic        stall,
    output logic [31:0] result,
    output logic        exception,
    output logic        result_valid,
    output logic        timeout
);

    if ((64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_cfg_check
        $error("multdiv_sequencer: CNT_W too narrow for TIMEOUT");
    end

    state_t state, state_nxt;
    logic   op_is_mult;
    logic   timed_out;
    logic   detect;
    logic   wd_expired;

    assign detect = (is_mult | is_div) & ~flush;

`ifdef MULTDIV_TIMEOUT_EN
    multdiv_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clr     ((state == ST_IDLE) && detect),
        .en      (state == ST_BUSY),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (detect) state_nxt = ST_START;
            ST_START: state_nxt = flush ? ST_IDLE : ST_BUSY;
            ST_BUSY: begin
                // flush beats a coincident unit_rdy
                if (flush)                        state_nxt = ST_IDLE;
                else if (unit_rdy || wd_expired)  state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            unit_operand_a <= '0;
            unit_operand_b <= '0;
            op_is_mult     <= 1'b0;
            result         <= '0;
            exception      <= 1'b0;
            timed_out      <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && detect) begin
                unit_operand_a <= operand_a;
                unit_operand_b <= operand_b;
                op_is_mult     <= is_mult;
            end
            if ((state == ST_BUSY) && !flush) begin
                if (unit_rdy) begin
                    result    <= unit_result;
                    exception <= unit_exception;
                    timed_out <= 1'b0;
                end else if (wd_expired) begin
                    result    <= '0;
                    exception <= 1'b1;
                    timed_out <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall        = 1'b0;
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        result_valid = 1'b0;
        timeout      = 1'b0;
        case (state)
            // Gated by reset so every output reads 0 while reset is held
            ST_IDLE:  stall = detect & reset;
            ST_START: begin
                stall     = 1'b1;
                ctrl_MULT = op_is_mult;
                ctrl_DIV  = ~op_is_mult;
            end
            ST_BUSY:  stall = 1'b1;
            ST_DONE: begin
                result_valid = ~flush;
`ifdef MULTDIV_TIMEOUT_EN
                timeout      = timed_out & ~flush;
`else
                timeout      = 1'b0;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Sequences the iterative multiply/divide unit used by the execute stage of the 5-stage pipeline. It detects a MUL/DIV instruction in X, latches its operands, and issues a single start pulse. It holds the pipeline stall while the unit iterates and returns the result and exception flag for exactly one cycle. It also supports flush cancellation and an optional hang watchdog.

## Interface
- `TIMEOUT`, default 64: maximum BUSY cycles allowed before the watchdog fires; only used when the watchdog is compiled in.
- `CNT_W`, default 7: width of the cycle counter; must satisfy 2^CNT_W > TIMEOUT.
- `clock`  in  1  master clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `is_mult`  in  1  X-stage instruction is MUL (opcode 00000, ALU op 00110).
- `is_div`  in  1  X-stage instruction is DIV (opcode 00000, ALU op 00111); never asserted together with `is_mult`.
- `flush`  in  1  X-stage instruction is being squashed.
- `operand_a`, `operand_b`  in  32  X-stage source values.
- `unit_result`  in  32  result from the iterative unit.
- `unit_exception`  in  1  overflow or divide-by-zero flag from the unit.
- `unit_rdy`  in  1  unit result valid.
- `ctrl_MULT`, `ctrl_DIV`  out  1  one-cycle start pulses to the unit.
- `unit_operand_a`, `unit_operand_b`  out  32  latched operands; stable from START until return to IDLE.
- `stall`  out  1  freeze PC, F/D, D/X, X/M and M/W latches.
- `result`  out  32  latched result; valid only while `result_valid` is 1.
- `exception`  out  1  latched exception; valid only while `result_valid` is 1.
- `result_valid`  out  1  one-cycle completion strobe.
- `timeout`  out  1  one-cycle watchdog strobe.

## Operation
The sequencer has four states: IDLE, START, BUSY, DONE.
- **IDLE**
  - `stall` = (`is_mult` | `is_div`) & ~`flush`, combinational so the stall is active in the detect cycle.
  - On that condition: latch the operands and the op type (mult or div), clear the counter, go to START.
- **START**
  - Pulse `ctrl_MULT` or `ctrl_DIV` according to the latched op type.
  - `stall` = 1.
  - `unit_rdy` is ignored (stale).
  - Go to BUSY.
- **BUSY**
  - `stall` = 1; the counter increments each cycle.
  - On `unit_rdy` = 1: latch `unit_result` and `unit_exception`, go to DONE.
- **DONE**
  - `stall` = 0; `result_valid` = 1.
  - The pipeline advances on this edge; the next state is always IDLE.
  - A back-to-back MUL/DIV is therefore detected in the following IDLE cycle.
- **`flush`** while in START, BUSY or DONE:
  - Next state is IDLE; no `result_valid` is produced.
  - `stall` drops in the cycle after `flush` is sampled.
  - A late `unit_rdy` is ignored.
  - The unit must restart cleanly on the next start pulse.
- `unit_rdy` and `flush` in the same BUSY cycle: `flush` wins.
- The counter saturates at 2^CNT_W−1; it never wraps.

## Timing
- **Reset:** state IDLE. All outputs 0 (including `stall`). Latched operands, result and counter are 0. Reset asserted mid-operation aborts immediately and asynchronously.
- **Latency:** unit asserts `unit_rdy` L cycles after the start pulse. With detect in cycle 0: pulse in cycle 1, `unit_rdy` in cycle 1+L, DONE in cycle L+2. `stall` is high for exactly L+2 cycles.
- **Pulses:** `ctrl_MULT`/`ctrl_DIV` are high exactly one cycle per accepted instruction; `result_valid` is high exactly one cycle.

## Configuration
- **`MULTDIV_TIMEOUT_EN` defined:** in BUSY, when the counter reaches `TIMEOUT` without `unit_rdy`:
  - `result` = 0, `exception` = 1, `timeout` = 1, go to DONE.
  - The DONE cycle then behaves as normal, with `result_valid` = 1.
- **`MULTDIV_TIMEOUT_EN` not defined:** BUSY waits indefinitely; `timeout` is tied to 0; `TIMEOUT` is unused.

## Structure
- Shared package `multdiv_seq_pkg` holds:
  - the state enum (IDLE, START, BUSY, DONE);
  - the opcode constant 00000;
  - the ALU-op constants MUL = 00110, DIV = 00111;
  - the default `TIMEOUT`.
- One natural sub-module, `multdiv_watchdog`: a saturating CNT_W-bit counter with clear, enable and terminal-count compare. It is instantiated only under `MULTDIV_TIMEOUT_EN`.

## Test plan
- **MUL 7×6, unit L=32** -> `ctrl_MULT` pulse in cycle 1; `stall` high for cycles 0–33; DONE in cycle 34 with `result` = 42, `exception` = 0, `result_valid` = 1 for one cycle.
- **DIV 100÷0, unit flags exception at L=32** -> `ctrl_DIV` pulse only; `exception` = 1 with `result_valid`; `ctrl_MULT` never asserted.
- **Back-to-back MUL then DIV** -> two separate pulses; the second is detected in the IDLE cycle after DONE; two `result_valid` strobes and no stall gap corruption.
- **`flush` in BUSY cycle 10** -> IDLE next cycle; `stall` = 0; no `result_valid`; a `unit_rdy` at cycle 33 is ignored.
- **`reset` dropped low in BUSY** -> all outputs 0 immediately; state IDLE after release.
- **`MULTDIV_TIMEOUT_EN`, TIMEOUT=64, `unit_rdy` never asserted** -> `timeout` = 1 after 64 BUSY cycles; `result` = 0, `exception` = 1, `result_valid` = 1. Without the macro, `stall` stays high.
